skew_operand_loader: RTL and testbench

- Parameterised operand staging buffer for the systolic matrix-multiply array.
- Accepts an operand matrix one row per cycle and stores ROWS rows of KDIM signed elements each.
- On command, streams the matrix out as ROWS lanes with lane r delayed r cycles (diagonal skew), with zero padding outside each lane's valid window.
- Generalises the fixed square loader: rectangular ROWS x KDIM, a load/stream handshake, per-lane valid flags, reuse of loaded data, and optional double buffering.

---
 rtl/skew_operand_loader.sv | 131 +++++++++++++
 tb/tb_skew_operand_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/skew_operand_loader.sv
// Stages a ROWS x KDIM signed operand matrix and streams it as diagonally skewed lanes; build option SKEW_LOADER_PINGPONG_EN adds a shadow bank.
// Latency: lane r shows element 0 at r+1 cycles after start is accepted; done pulses the cycle after the last element.
// Backpressure: wr_ready drops while streaming (single bank); with ping-pong, writes go to the shadow bank and wr_ready stays high.
module skew_operand_loader #(
    parameter int BITS = 8,
    parameter int ROWS = 8,
    parameter int KDIM = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic signed [BITS-1:0]  wr_data [KDIM],
    output logic                    wr_ready,
    input  logic                    clr,
    input  logic                    start,
    output logic                    loaded,
    output logic                    busy,
    output logic signed [BITS-1:0]  out_data [ROWS],
    output logic [ROWS-1:0]         out_valid,
    output logic                    done
);
    localparam int KW   = $clog2(KDIM);
    localparam int CW   = $clog2(KDIM + ROWS) + 1;
    localparam int LAST = KDIM + ROWS - 2;
`ifdef SKEW_LOADER_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, READY, STREAM} state_t;

    state_t                 state;
    logic [CW-1:0]          col;
    logic                   act;
    logic [ROWS-1:0]        bmap [2];
    logic signed [BITS-1:0] mem  [2][ROWS][KDIM];

    logic                   wbank, rbank;
    logic                   wr_acc, clr_acc, last_col, start_acc, step, show;
    logic [CW-1:0]          show_col;
    logic [ROWS-1:0]        bmap_w, nxt_vld;
    logic signed [BITS-1:0] nxt_dat [ROWS];
    logic                   nxt_stream, nxt_loaded;

    always_comb begin
        // Single bank: act stays 0, so reads and writes both use bank 0.
        wbank    = act ^ PP;
        wr_acc   = wr_en && wr_ready && (int'(wr_row) < ROWS);
        clr_acc  = clr && (PP || state != STREAM);
        last_col = (state == STREAM) && (col == CW'(LAST));
        if (PP)
            start_acc = start && (&bmap[wbank]) && (state == READY || last_col);
        else
            start_acc = start && (state == READY);
        rbank    = start_acc ? wbank : act;
        step     = (state == STREAM) && !last_col;
        show     = start_acc || step;
        show_col = start_acc ? '0 : col + CW'(1);

        bmap_w = clr_acc ? '0 : bmap[wbank];
        if (wr_acc)
            bmap_w[wr_row] = 1'b1;
        nxt_loaded = (start_acc && PP) ? 1'b0 : &bmap_w;
        nxt_stream = show;

        // Lane r carries element (col - r); a write landing on the start edge is forwarded.
        for (int r = 0; r < ROWS; r++) begin
            int idx;
            idx        = int'(show_col) - r;
            nxt_vld[r] = 1'b0;
            nxt_dat[r] = '0;
            if (show && idx >= 0 && idx < KDIM) begin
                nxt_vld[r] = 1'b1;
                if (wr_acc && wbank == rbank && int'(wr_row) == r)
                    nxt_dat[r] = wr_data[idx[KW-1:0]];
                else
                    nxt_dat[r] = mem[rbank][r][idx[KW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            col       <= '0;
            act       <= 1'b0;
            bmap[0]   <= '0;
            bmap[1]   <= '0;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < ROWS; r++)
                    for (int k = 0; k < KDIM; k++)
                        mem[b][r][k] <= '0;
            for (int r = 0; r < ROWS; r++)
                out_data[r] <= '0;
            out_valid <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            loaded    <= 1'b0;
            wr_ready  <= 1'b1;
        end else begin
            if (wr_acc)
                for (int k = 0; k < KDIM; k++)
                    mem[wbank][wr_row][k] <= wr_data[k];
            bmap[wbank] <= bmap_w;
            if (start_acc && PP) begin
                // Swap: the bank just streamed becomes the empty shadow.
                bmap[~wbank] <= '0;
                act          <= ~act;
            end

            col <= show ? show_col : '0;
            if (nxt_stream)
                state <= STREAM;
            else if (nxt_loaded)
                state <= READY;
            else
                state <= IDLE;

            busy      <= nxt_stream;
            wr_ready  <= PP || !nxt_stream;
            loaded    <= nxt_loaded;
            done      <= last_col;
            out_valid <= nxt_vld;
            for (int r = 0; r < ROWS; r++)
                out_data[r] <= nxt_dat[r];
        end
    end

endmodule

// File: tb/tb_skew_operand_loader.sv
// Scoreboard bench for skew_operand_loader at ROWS=4, KDIM=4, BITS=8.
// Expected per-cycle lane outputs are queued when a stream is started and compared every negedge.
module tb_skew_operand_loader;
    localparam int BITS = 8;
    localparam int ROWS = 4;
    localparam int KDIM = 4;
    localparam int NC   = KDIM + ROWS - 1;
`ifdef SKEW_LOADER_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   wr_en = 1'b0;
    logic                   clr = 1'b0;
    logic                   start = 1'b0;
    logic [1:0]             wr_row = 2'd0;
    logic signed [BITS-1:0] wr_data [KDIM];
    logic                   wr_ready, loaded, busy, done;
    logic signed [BITS-1:0] out_data [ROWS];
    logic [ROWS-1:0]        out_valid;

    typedef struct packed {
        logic [ROWS-1:0] vld;
        logic [31:0]     dat;
        logic            done;
        logic            busy;
    } rec_t;

    rec_t            sb[$];
    logic [7:0]      mrow [ROWS][KDIM];
    logic [ROWS-1:0] mbits;
    int              n_tests = 0;
    int              n_fail = 0;
    bit              mon_en = 1'b0;

    always #5 clk = ~clk;

    skew_operand_loader #(.BITS(BITS), .ROWS(ROWS), .KDIM(KDIM)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .wr_ready(wr_ready), .clr(clr), .start(start), .loaded(loaded), .busy(busy),
        .out_data(out_data), .out_valid(out_valid), .done(done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_out();
        logic [31:0] v;
        for (int r = 0; r < ROWS; r++)
            v[8*r +: 8] = out_data[r];
        return v;
    endfunction

    function automatic logic [31:0] pat(input int r);
        logic [31:0] v;
        for (int k = 0; k < KDIM; k++)
            v[8*k +: 8] = 8'(16 * r + k);
        return v;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            rec_t e;
            e = '0;
            if (sb.size() > 0)
                e = sb.pop_front();
            chk("out_valid", 64'(out_valid), 64'(e.vld));
            chk("out_data", 64'(pack_out()), 64'(e.dat));
            chk("done", 64'(done), 64'(e.done));
            chk("busy", 64'(busy), 64'(e.busy));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_stream();
        rec_t e;
        logic carry_done;
        carry_done = 1'b0;
        if (sb.size() > 0) begin
            e = sb.pop_back();
            carry_done = e.done;
        end
        for (int c = 0; c < NC; c++) begin
            e = '0;
            e.busy = 1'b1;
            if (c == 0)
                e.done = carry_done;
            for (int r = 0; r < ROWS; r++)
                if (c - r >= 0 && c - r < KDIM) begin
                    e.vld[r] = 1'b1;
                    e.dat[8*r +: 8] = mrow[r][c-r];
                end
            sb.push_back(e);
        end
        e = '0;
        e.done = 1'b1;
        sb.push_back(e);
        if (PP)
            mbits = '0;
    endtask

    task automatic drive_row(input int r, input logic [31:0] d, input bit with_clr);
        wr_en  = 1'b1;
        wr_row = 2'(r);
        clr    = with_clr;
        for (int k = 0; k < KDIM; k++)
            wr_data[k] = d[8*k +: 8];
    endtask

    task automatic model_row(input int r, input logic [31:0] d);
        for (int k = 0; k < KDIM; k++)
            mrow[r][k] = d[8*k +: 8];
        mbits[r] = 1'b1;
    endtask

    task automatic write_row(input int r, input logic [31:0] d, input bit with_clr);
        drive_row(r, d, with_clr);
        tick();
        wr_en = 1'b0;
        clr   = 1'b0;
        if (with_clr)
            mbits = '0;
        model_row(r, d);
    endtask

    task automatic start_stream(input bit acc);
        start = 1'b1;
        @(posedge clk);
        if (acc)
            push_stream();
        #1;
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++)
            tick();
        chk("drain", 64'(sb.size()), 64'(0));
        tick();
    endtask

    initial begin
        for (int k = 0; k < KDIM; k++)
            wr_data[k] = '0;
        mbits = '0;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < KDIM; k++)
                mrow[r][k] = '0;

        repeat (3) tick();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(pack_out()), 64'(0));
        chk("rst_wr_ready", 64'(wr_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_loaded", 64'(loaded), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

`ifndef SKEW_LOADER_PINGPONG_EN
        for (int r = 0; r < 3; r++)
            write_row(r, pat(r), 1'b0);
        chk("loaded_partial", 64'(loaded), 64'(mbits == 4'hF));
        start_stream(1'b0);
        tick();
        chk("start_idle_busy", 64'(busy), 64'(0));
        write_row(3, pat(3), 1'b0);
        chk("loaded_full", 64'(loaded), 64'(1));

        start_stream(1'b1);
        chk("wr_ready_stream", 64'(wr_ready), 64'(0));
        drive_row(0, 32'hFFFF_FFFF, 1'b0);
        tick();
        wr_en = 1'b0;
        drain();
        chk("loaded_after", 64'(loaded), 64'(1));

        start_stream(1'b1);
        drain();

        clr = 1'b1;
        tick();
        clr = 1'b0;
        mbits = '0;
        chk("loaded_clr", 64'(loaded), 64'(0));
        start_stream(1'b0);
        tick();
        chk("start_cleared_busy", 64'(busy), 64'(0));

        write_row(1, pat(1), 1'b1);
        chk("clr_wr_loaded", 64'(loaded), 64'(0));
        write_row(0, pat(0), 1'b0);
        write_row(2, pat(2), 1'b0);
        chk("row3_missing", 64'(loaded), 64'(0));
        write_row(1, 32'h007F_FF80, 1'b0);
        write_row(3, pat(3), 1'b0);
        chk("reloaded", 64'(loaded), 64'(1));

        drive_row(0, 32'hA3A2_A1A0, 1'b0);
        model_row(0, 32'hA3A2_A1A0);
        start_stream(1'b1);
        wr_en = 1'b0;
        drain();

        start_stream(1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        sb.delete();
        mbits = '0;
        #3;
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        chk("abort_out_data", 64'(pack_out()), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_loaded", 64'(loaded), 64'(mbits == 4'hF));
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        chk("post_abort_loaded", 64'(loaded), 64'(0));
`else
        for (int r = 0; r < ROWS; r++)
            write_row(r, pat(r), 1'b0);
        chk("pp_loaded_a", 64'(loaded), 64'(1));
        start_stream(1'b1);
        chk("pp_loaded_swap", 64'(loaded), 64'(0));
        chk("pp_wr_ready", 64'(wr_ready), 64'(1));
        for (int r = 0; r < ROWS; r++)
            write_row(r, pat(r) ^ 32'h8080_8080, 1'b0);
        chk("pp_loaded_b", 64'(loaded), 64'(1));
        tick();
        tick();
        start_stream(1'b1);
        drain();
        chk("pp_loaded_end", 64'(loaded), 64'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
